exec_lane_splitter: RTL and testbench

Splits one full-warp execute request (`NUM_THREADS` lanes) into a sequence of `NUM_LANES`-wide packets for a narrower functional unit. Each packet is tagged with a batch index (`pid`) and start/end-of-packet flags (`sop`/`eop`). The block sits between the dispatch stage and a functional unit whose datapath is narrower than the warp. It holds one request in a single-entry buffer and emits `BATCHES = NUM_THREADS/NUM_LANES` packets, one per cycle under backpressure.

---
 rtl/exec_lane_splitter.sv | 242 ++++++++++++++++++++++++
 tb/tb_exec_lane_splitter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_lane_splitter.sv
// ---------------------------------------------------------------------------
// exec_lane_splitter
//
// Splits one full-warp execute request (NUM_THREADS lanes) into a sequence of
// NUM_LANES-wide packets for a narrower functional unit. The request is held
// in a single-entry buffer. One packet is emitted per cycle, and emission
// stalls under backpressure. Each packet carries its batch index (pid_out)
// and first/last flags (sop_out/eop_out).
//
// Optional feature macro:
//   EXEC_SPLIT_SKIP_EMPTY_EN - when defined, batches whose tmask slice is
//                              all-zero are not emitted. An all-zero mask
//                              still emits a single packet with pid 0.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   valid_in   in   request valid
//   meta_in    in   lane-independent payload, passed through untouched
//   tmask_in   in   thread mask, NUM_THREADS bits
//   rs1/2/3_in in   operands, lane i at [i*XLEN +: XLEN]
//   ready_in   out  request accepted when valid_in && ready_in
//   valid_out  out  packet valid
//   meta_out   out  captured meta_in
//   tmask_out  out  mask slice of the current batch (0 when idle)
//   rs1/2/3_out out operand slices of the current batch
//   pid_out    out  batch index
//   sop_out    out  first packet of the request
//   eop_out    out  last packet of the request
//   ready_out  in   packet consumed when valid_out && ready_out
// ---------------------------------------------------------------------------
module exec_lane_splitter #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NUM_LANES   = 1,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned META_W      = 64,
    parameter int unsigned PID_W       = ((NUM_THREADS / NUM_LANES) > 1)
                                         ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        valid_in,
    input  logic [META_W-1:0]           meta_in,
    input  logic [NUM_THREADS-1:0]      tmask_in,
    input  logic [NUM_THREADS*XLEN-1:0] rs1_in,
    input  logic [NUM_THREADS*XLEN-1:0] rs2_in,
    input  logic [NUM_THREADS*XLEN-1:0] rs3_in,
    output logic                        ready_in,

    output logic                        valid_out,
    output logic [META_W-1:0]           meta_out,
    output logic [NUM_LANES-1:0]        tmask_out,
    output logic [NUM_LANES*XLEN-1:0]   rs1_out,
    output logic [NUM_LANES*XLEN-1:0]   rs2_out,
    output logic [NUM_LANES*XLEN-1:0]   rs3_out,
    output logic [PID_W-1:0]            pid_out,
    output logic                        sop_out,
    output logic                        eop_out,
    input  logic                        ready_out
);

    localparam int unsigned BATCHES = NUM_THREADS / NUM_LANES;
    localparam int unsigned SLICE_W = NUM_LANES * XLEN;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Request buffer
    logic [META_W-1:0]           meta_q;
    logic [NUM_THREADS-1:0]      tmask_q;
    logic [NUM_THREADS*XLEN-1:0] rs1_q;
    logic [NUM_THREADS*XLEN-1:0] rs2_q;
    logic [NUM_THREADS*XLEN-1:0] rs3_q;

    // Batch sequencing
    logic [PID_W-1:0] pid_q, pid_d;
    logic             first_q, first_d;

    logic             accept;
    logic             fire;
    logic             last;
    logic [PID_W-1:0] first_pid;
    logic [PID_W-1:0] next_pid;

    logic [NUM_LANES-1:0] tmask_sl;
    logic [SLICE_W-1:0]   rs1_sl;
    logic [SLICE_W-1:0]   rs2_sl;
    logic [SLICE_W-1:0]   rs3_sl;

    assign accept = valid_in && ready_in;
    assign fire   = valid_out && ready_out;

    // ------------------------------------------------------------------
    // Batch selection: slice mux driven only by registered state.
    // ------------------------------------------------------------------
    always_comb begin
        tmask_sl = '0;
        rs1_sl   = '0;
        rs2_sl   = '0;
        rs3_sl   = '0;
        for (int unsigned b = 0; b < BATCHES; b++) begin
            if (pid_q == PID_W'(b)) begin
                tmask_sl = tmask_q[b*NUM_LANES +: NUM_LANES];
                rs1_sl   = rs1_q[b*SLICE_W +: SLICE_W];
                rs2_sl   = rs2_q[b*SLICE_W +: SLICE_W];
                rs3_sl   = rs3_q[b*SLICE_W +: SLICE_W];
            end
        end
    end

`ifdef EXEC_SPLIT_SKIP_EMPTY_EN
    logic [BATCHES-1:0] batch_nz;

    always_comb begin
        batch_nz = '0;
        for (int unsigned b = 0; b < BATCHES; b++) begin
            batch_nz[b] = |tmask_q[b*NUM_LANES +: NUM_LANES];
        end
    end

    // Lowest non-empty batch of the incoming mask; 0 when the mask is empty.
    // Scanning downward lets the lowest hit win.
    always_comb begin
        first_pid = '0;
        for (int unsigned b = BATCHES; b > 0; b--) begin
            if (|tmask_in[(b-1)*NUM_LANES +: NUM_LANES]) begin
                first_pid = PID_W'(b - 1);
            end
        end
    end

    // Lowest non-empty batch above pid_q; none left means this is the last.
    always_comb begin
        next_pid = pid_q;
        last     = 1'b1;
        for (int unsigned b = BATCHES; b > 0; b--) begin
            if (batch_nz[b-1] && (PID_W'(b - 1) > pid_q)) begin
                next_pid = PID_W'(b - 1);
                last     = 1'b0;
            end
        end
    end
`else
    always_comb begin
        first_pid = '0;
        next_pid  = pid_q + PID_W'(1);
        last      = (pid_q == PID_W'(BATCHES - 1));
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // A request accepted on the final handshake keeps us in SEND.
                if (fire && last && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        valid_out = (state_q == SEND);
        sop_out   = valid_out && first_q;
        eop_out   = valid_out && last;
        tmask_out = valid_out ? tmask_sl : '0;
        ready_in  = (state_q == IDLE) || (valid_out && ready_out && eop_out);
    end

    assign meta_out = meta_q;
    assign rs1_out  = rs1_sl;
    assign rs2_out  = rs2_sl;
    assign rs3_out  = rs3_sl;
    assign pid_out  = pid_q;

    // ------------------------------------------------------------------
    // Batch counter and first-packet flag
    // ------------------------------------------------------------------
    always_comb begin
        pid_d   = pid_q;
        first_d = first_q;
        if (accept) begin
            pid_d   = first_pid;
            first_d = 1'b1;
        end else if (fire) begin
            first_d = 1'b0;
            pid_d   = last ? '0 : next_pid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pid_q   <= '0;
            first_q <= 1'b0;
            meta_q  <= '0;
            tmask_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
        end else begin
            pid_q   <= pid_d;
            first_q <= first_d;
            if (accept) begin
                meta_q  <= meta_in;
                tmask_q <= tmask_in;
                rs1_q   <= rs1_in;
                rs2_q   <= rs2_in;
                rs3_q   <= rs3_in;
            end
        end
    end

endmodule

// File: tb/tb_exec_lane_splitter.sv
module tb_exec_lane_splitter;

    logic clk;
    logic reset;

    int checks;
    int failures;

    // Narrow instance: 4 threads, 1 lane per packet
    logic         valid_in;
    logic [63:0]  meta_in;
    logic [3:0]   tmask_in;
    logic [127:0] rs1_in, rs2_in, rs3_in;
    logic         ready_in;
    logic         valid_out;
    logic [63:0]  meta_out;
    logic [0:0]   tmask_out;
    logic [31:0]  rs1_out, rs2_out, rs3_out;
    logic [1:0]   pid_out;
    logic         sop_out, eop_out;
    logic         ready_out;

    // Wide instance: 8 threads, 4 lanes per packet
    logic         w_valid_in;
    logic [63:0]  w_meta_in;
    logic [7:0]   w_tmask_in;
    logic [255:0] w_rs1_in, w_rs2_in, w_rs3_in;
    logic         w_ready_in;
    logic         w_valid_out;
    logic [63:0]  w_meta_out;
    logic [3:0]   w_tmask_out;
    logic [127:0] w_rs1_out, w_rs2_out, w_rs3_out;
    logic [0:0]   w_pid_out;
    logic         w_sop_out, w_eop_out;
    logic         w_ready_out;

    exec_lane_splitter #(
        .NUM_THREADS(4),
        .NUM_LANES  (1),
        .XLEN       (32),
        .META_W     (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .meta_in   (meta_in),
        .tmask_in  (tmask_in),
        .rs1_in    (rs1_in),
        .rs2_in    (rs2_in),
        .rs3_in    (rs3_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .meta_out  (meta_out),
        .tmask_out (tmask_out),
        .rs1_out   (rs1_out),
        .rs2_out   (rs2_out),
        .rs3_out   (rs3_out),
        .pid_out   (pid_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .ready_out (ready_out)
    );

    exec_lane_splitter #(
        .NUM_THREADS(8),
        .NUM_LANES  (4),
        .XLEN       (32),
        .META_W     (64)
    ) dut_w (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (w_valid_in),
        .meta_in   (w_meta_in),
        .tmask_in  (w_tmask_in),
        .rs1_in    (w_rs1_in),
        .rs2_in    (w_rs2_in),
        .rs3_in    (w_rs3_in),
        .ready_in  (w_ready_in),
        .valid_out (w_valid_out),
        .meta_out  (w_meta_out),
        .tmask_out (w_tmask_out),
        .rs1_out   (w_rs1_out),
        .rs2_out   (w_rs2_out),
        .rs3_out   (w_rs3_out),
        .pid_out   (w_pid_out),
        .sop_out   (w_sop_out),
        .eop_out   (w_eop_out),
        .ready_out (w_ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Narrow request: lane i of rs1/rs2/rs3 = base+i / base+0x100+i / base+0x200+i
    task automatic load(input logic [31:0] base, input logic [3:0] mask);
        valid_in = 1'b1;
        tmask_in = mask;
        meta_in  = {32'hCAFE0000, base};
        for (int i = 0; i < 4; i++) begin
            rs1_in[i*32 +: 32] = base + 32'(i);
            rs2_in[i*32 +: 32] = base + 32'h100 + 32'(i);
            rs3_in[i*32 +: 32] = base + 32'h200 + 32'(i);
        end
    endtask

    task automatic pkt(input string tag, input logic [31:0] base, input int pid,
                       input logic sop, input logic eop, input logic tm);
        chk({tag, ".valid"}, 128'(valid_out), 128'(1'b1));
        chk({tag, ".pid"},   128'(pid_out),   128'(pid));
        chk({tag, ".rs1"},   128'(rs1_out),   128'(base + 32'(pid)));
        chk({tag, ".rs2"},   128'(rs2_out),   128'(base + 32'h100 + 32'(pid)));
        chk({tag, ".rs3"},   128'(rs3_out),   128'(base + 32'h200 + 32'(pid)));
        chk({tag, ".sop"},   128'(sop_out),   128'(sop));
        chk({tag, ".eop"},   128'(eop_out),   128'(eop));
        chk({tag, ".tmask"}, 128'(tmask_out), 128'(tm));
        chk({tag, ".meta"},  128'(meta_out),  128'({32'hCAFE0000, base}));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        valid_in   = 1'b0;
        meta_in    = '0;
        tmask_in   = '0;
        rs1_in     = '0;
        rs2_in     = '0;
        rs3_in     = '0;
        ready_out  = 1'b1;
        w_valid_in = 1'b0;
        w_meta_in  = '0;
        w_tmask_in = '0;
        w_rs1_in   = '0;
        w_rs2_in   = '0;
        w_rs3_in   = '0;
        w_ready_out = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.valid_out", 128'(valid_out), 128'(1'b0));
        chk("rst.ready_in",  128'(ready_in),  128'(1'b1));
        chk("rst.sop",       128'(sop_out),   128'(1'b0));
        chk("rst.eop",       128'(eop_out),   128'(1'b0));
        chk("rst.tmask",     128'(tmask_out), 128'(1'b0));
        chk("rst.w_valid",   128'(w_valid_out), 128'(1'b0));
        chk("rst.w_ready_in", 128'(w_ready_in), 128'(1'b1));

        // Basic split: 4 packets, pid 0..3, rs1 0x10..0x13
        load(32'h10, 4'b1111);
        #1;
        chk("A.accept_ready", 128'(ready_in), 128'(1'b1));
        @(negedge clk);
        valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pkt($sformatf("A%0d", k), 32'h10, k, k == 0, k == 3, 1'b1);
            chk($sformatf("A%0d.ready_in", k), 128'(ready_in), 128'(k == 3));
            @(negedge clk);
        end
        chk("A.idle_after", 128'(valid_out), 128'(1'b0));

        // Backpressure: hold at pid 1 for 3 cycles
        load(32'h20, 4'b1111);
        @(negedge clk);
        valid_in = 1'b0;
        pkt("B0", 32'h20, 0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            pkt($sformatf("B1hold%0d", k), 32'h20, 1, 1'b0, 1'b0, 1'b1);
            chk($sformatf("B1hold%0d.ready_in", k), 128'(ready_in), 128'(1'b0));
            @(negedge clk);
        end
        ready_out = 1'b1;
        #1;
        pkt("B1", 32'h20, 1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        pkt("B2", 32'h20, 2, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Back-to-back: next request offered during B's eop handshake
        load(32'h30, 4'b1111);
        #1;
        pkt("B3", 32'h20, 3, 1'b0, 1'b1, 1'b1);
        chk("B3.ready_in", 128'(ready_in), 128'(1'b1));
        @(negedge clk);
        valid_in = 1'b0;
        pkt("C0", 32'h30, 0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        pkt("C1", 32'h30, 1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Reset mid-request at pid 2
        pkt("C2", 32'h30, 2, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2.valid_out", 128'(valid_out), 128'(1'b0));
        chk("rst2.ready_in",  128'(ready_in),  128'(1'b1));
        chk("rst2.sop",       128'(sop_out),   128'(1'b0));
        chk("rst2.eop",       128'(eop_out),   128'(1'b0));
        chk("rst2.tmask",     128'(tmask_out), 128'(1'b0));
        load(32'h50, 4'b1111);
        @(negedge clk);
        valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pkt($sformatf("D%0d", k), 32'h50, k, k == 0, k == 3, 1'b1);
            @(negedge clk);
        end
        chk("D.idle_after", 128'(valid_out), 128'(1'b0));

        // Sparse mask 4'b1010
        load(32'h60, 4'b1010);
        @(negedge clk);
        valid_in = 1'b0;
`ifdef EXEC_SPLIT_SKIP_EMPTY_EN
        pkt("E1", 32'h60, 1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        pkt("E3", 32'h60, 3, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
`else
        for (int k = 0; k < 4; k++) begin
            pkt($sformatf("E%0d", k), 32'h60, k, k == 0, k == 3, (k % 2) == 1);
            @(negedge clk);
        end
`endif
        chk("E.idle_after", 128'(valid_out), 128'(1'b0));

        // All-zero mask
        load(32'h70, 4'b0000);
        @(negedge clk);
        valid_in = 1'b0;
`ifdef EXEC_SPLIT_SKIP_EMPTY_EN
        pkt("F0", 32'h70, 0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
`else
        for (int k = 0; k < 4; k++) begin
            pkt($sformatf("F%0d", k), 32'h70, k, k == 0, k == 3, 1'b0);
            @(negedge clk);
        end
`endif
        chk("F.idle_after", 128'(valid_out), 128'(1'b0));

        // Wide lanes: 8 threads, 4 lanes, tmask 8'hF0, lane i rs1 = 0x40+i
        w_valid_in = 1'b1;
        w_tmask_in = 8'hF0;
        w_meta_in  = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 8; i++) begin
            w_rs1_in[i*32 +: 32] = 32'h40 + 32'(i);
            w_rs2_in[i*32 +: 32] = 32'h140 + 32'(i);
            w_rs3_in[i*32 +: 32] = 32'h240 + 32'(i);
        end
        @(negedge clk);
        w_valid_in = 1'b0;
`ifndef EXEC_SPLIT_SKIP_EMPTY_EN
        chk("W0.valid", 128'(w_valid_out), 128'(1'b1));
        chk("W0.pid",   128'(w_pid_out),   128'(1'b0));
        chk("W0.tmask", 128'(w_tmask_out), 128'(4'h0));
        chk("W0.rs1",   128'(w_rs1_out),   {32'h43, 32'h42, 32'h41, 32'h40});
        chk("W0.rs3",   128'(w_rs3_out),   {32'h243, 32'h242, 32'h241, 32'h240});
        chk("W0.sop",   128'(w_sop_out),   128'(1'b1));
        chk("W0.eop",   128'(w_eop_out),   128'(1'b0));
        @(negedge clk);
`endif
        chk("W1.valid", 128'(w_valid_out), 128'(1'b1));
        chk("W1.pid",   128'(w_pid_out),   128'(1'b1));
        chk("W1.tmask", 128'(w_tmask_out), 128'(4'hF));
        chk("W1.rs1",   128'(w_rs1_out),   {32'h47, 32'h46, 32'h45, 32'h44});
        chk("W1.rs2",   128'(w_rs2_out),   {32'h147, 32'h146, 32'h145, 32'h144});
        chk("W1.meta",  128'(w_meta_out),  128'(64'h1234_5678_9ABC_DEF0));
`ifdef EXEC_SPLIT_SKIP_EMPTY_EN
        chk("W1.sop",   128'(w_sop_out),   128'(1'b1));
`else
        chk("W1.sop",   128'(w_sop_out),   128'(1'b0));
`endif
        chk("W1.eop",   128'(w_eop_out),   128'(1'b1));
        @(negedge clk);
        chk("W.idle_after", 128'(w_valid_out), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
